m_ext_divider: RTL and testbench

//   Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.

---
 rtl/m_ext_divider.sv | 141 ++++++++++++++
 tb/tb_m_ext_divider.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_divider.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at issue without iterating.
module m_ext_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);
  localparam logic [CNT_W-1:0] CNT_DEC  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic is_signed);
    return cond_neg(v, is_signed && v[XLEN-1]);
  endfunction

  state_t           state_q, state_d;
  logic [XLEN-1:0]  quo_dvd_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  result_q;
  logic             valid_q;

  // Issue decode: operand signs and the two cases that bypass iteration
  logic            is_signed_d;
  logic            sign1_d, sign2_d;
  logic            div_zero_d, overflow_d, special_d;
  logic [XLEN-1:0] special_res_d;
  logic            accept;

  assign is_signed_d   = ~op_i[0];
  assign sign1_d       = is_signed_d & rs1_i[XLEN-1];
  assign sign2_d       = is_signed_d & rs2_i[XLEN-1];
  assign div_zero_d    = (rs2_i == '0);
  assign overflow_d    = is_signed_d && (rs1_i == INT_MIN) && (rs2_i == '1);
  assign special_d     = div_zero_d | overflow_d;
  assign special_res_d = div_zero_d ? (op_i[1] ? rs1_i : '1)
                                    : (op_i[1] ? '0 : INT_MIN);
  assign accept        = (state_q == S_IDLE) && start_i && !flush_i;

  // One restoring step; the extra top bit keeps the compare exact for divisors >= 2^(XLEN-1)
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            step_ge;
  logic [XLEN-1:0] rem_nx, quo_nx, final_res;

  assign rem_sh    = {rem_q, quo_dvd_q[XLEN-1]};
  assign rem_sub   = rem_sh - {1'b0, dvs_q};
  assign step_ge   = ~rem_sub[XLEN];
  assign rem_nx    = step_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx    = {quo_dvd_q[XLEN-2:0], step_ge};
  assign final_res = op_rem_q ? cond_neg(rem_nx, neg_rem_q) : cond_neg(quo_nx, neg_quo_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) state_d = special_d ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (flush_i)              state_d = S_IDLE;
        else if (cnt_q == '0)     state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // The dividend shifts out of the top of quo_dvd_q while quotient bits shift in at the bottom
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_dvd_q <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        op_rem_q  <= op_i[1];
        neg_quo_q <= sign1_d ^ sign2_d;
        neg_rem_q <= sign1_d;
        quo_dvd_q <= magnitude(rs1_i, is_signed_d);
        dvs_q     <= magnitude(rs2_i, is_signed_d);
        rem_q     <= '0;
        cnt_q     <= CNT_LAST;
        if (special_d) begin
          result_q <= special_res_d;
          valid_q  <= 1'b1;
        end
      end else if (state_q == S_BUSY && !flush_i) begin
        quo_dvd_q <= quo_nx;
        rem_q     <= rem_nx;
        cnt_q     <= cnt_q - CNT_DEC;
        if (cnt_q == '0) begin
          result_q <= final_res;
          valid_q  <= 1'b1;
        end
      end
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_m_ext_divider.sv
// Directed bench for m_ext_divider: corner cases, latency, flush/reset aborts and a
// table sweep of signed/unsigned operands against a behavioural reference.
module tb_m_ext_divider;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int checks = 0;
  int errors = 0;

  m_ext_divider #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // lat = 1 means valid_o was already high in the first cycle after the accepting edge
  task automatic wait_valid(output logic [31:0] res, output int lat);
    lat = 1;
    while (valid_o !== 1'b1 && lat <= XLEN + 8) begin
      step();
      lat++;
    end
    res = result_o;
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; flush_i = 1'b0; op_i = 2'b01;
    rs1_i = 32'd100; rs2_i = 32'd7;
    step(); step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    start_i = 1'b0; rst_n = 1'b1;
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_signed();
    logic [31:0] res; int lat;
    issue(2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_valid(res, lat);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_m7_2_latency: got %0d want 33", lat); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b want 0", valid_o); end
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_valid(res, lat);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL rem_m7_2_latency: got %0d want 33", lat); end
    step();
  endtask

  task automatic test_unsigned();
    logic [31:0] res; int lat; int nbusy; int vcyc;
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    nbusy = 0; vcyc = 0; res = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      if (busy_o === 1'b1) nbusy++;
      if (valid_o === 1'b1 && vcyc == 0) begin vcyc = i; res = result_o; end
      step();
    end
    checks++; if (res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL divu_max_2: got %h want 7fffffff", res); end
    checks++; if (nbusy !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 33", nbusy); end
    checks++; if (vcyc !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", vcyc); end
    issue(2'b11, 32'hFFFF_FFFF, 32'd2);
    wait_valid(res, lat);
    checks++; if (res !== 32'h1) begin errors++; $display("FAIL remu_max_2: got %h want 1", res); end
    step();
  endtask

  task automatic test_div_zero();
    logic [31:0] res; int lat;
    issue(2'b00, 32'd5, 32'd0);
    wait_valid(res, lat);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got %h want ffffffff", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_by_zero_latency: got %0d want 1", lat); end
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL div_by_zero_busy: got %b want 0", busy_o); end
    issue(2'b11, 32'd5, 32'd0);
    wait_valid(res, lat);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu_by_zero: got %h want 5", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL remu_by_zero_latency: got %0d want 1", lat); end
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] res; int lat;
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(res, lat);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h want 80000000", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_overflow_latency: got %0d want 1", lat); end
    step();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(res, lat);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_overflow: got %h want 0", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL rem_overflow_latency: got %0d want 1", lat); end
    step();
  endtask

  task automatic test_start_ignored();
    logic [31:0] res; int lat;
    op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
    step();
    op_i = 2'b00; rs1_i = 32'd1000; rs2_i = 32'd3;
    lat = 1;
    while (valid_o !== 1'b1 && lat <= XLEN + 8) begin step(); lat++; end
    res = result_o;
    start_i = 1'b0;
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL start_held_result: got %h want e", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL start_held_latency: got %0d want 33", lat); end
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_not_queued: busy %b want 0", busy_o); end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; int nvalid;
    issue(2'b11, 32'd100, 32'd7);
    wait_valid(res, lat);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want 2", res); end
    step();
    issue(2'b00, 32'd1000, 32'd3);
    repeat (9) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== 32'd2) begin errors++; $display("FAIL flush_result_held: got %h want 2", result_o); end
    nvalid = 0;
    repeat (40) begin
      if (valid_o !== 1'b0 || busy_o !== 1'b0) nvalid++;
      step();
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL flush_no_late_valid: got %0d active cycles want 0", nvalid); end
    op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1; flush_i = 1'b1;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_blocks_start: busy %b want 0", busy_o); end
    issue(2'b01, 32'd100, 32'd7);
    wait_valid(res, lat);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_after_flush: got %h want e", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_after_flush_latency: got %0d want 33", lat); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat;
    issue(2'b01, 32'hFFFF_FFFF, 32'd3);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h want 0", result_o); end
    issue(2'b00, 32'd100, 32'hFFFF_FFF9);
    wait_valid(res, lat);
    checks++; if (res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_m7: got %h want fffffff2", res); end
    step();
    issue(2'b10, 32'd100, 32'hFFFF_FFF9);
    wait_valid(res, lat);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_100_m7: got %h want 2", res); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat;
    issue(2'b01, 32'd20, 32'd3);
    wait_valid(res, lat);
    checks++; if (res !== 32'd6) begin errors++; $display("FAIL b2b_divu_20_3: got %h want 6", res); end
    step();
    issue(2'b10, 32'hFFFF_FFEC, 32'd3);
    wait_valid(res, lat);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_rem_m20_3: got %h want fffffffe", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_rem_latency: got %0d want 33", lat); end
    step();
    issue(2'b00, 32'd7, 32'd0);
    wait_valid(res, lat);
    step();
    issue(2'b10, 32'd7, 32'd0);
    wait_valid(res, lat);
    checks++; if (res !== 32'd7) begin errors++; $display("FAIL b2b_special_rem: got %h want 7", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_special_latency: got %0d want 1", lat); end
    step();
  endtask

  task automatic test_sweep();
    logic [31:0] vals [8];
    logic [31:0] res, exp;
    int lat, exp_lat;
    vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFF9,
             32'h8000_0000, 32'h7FFF_FFFF, 32'h9ABC_DEF1};
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          exp     = ref_result(2'(o), vals[i], vals[j]);
          exp_lat = ref_latency(2'(o), vals[i], vals[j]);
          issue(2'(o), vals[i], vals[j]);
          wait_valid(res, lat);
          checks++;
          if (res !== exp || lat !== exp_lat) begin
            errors++;
            $display("FAIL sweep op%0d %h/%h: got %h lat %0d want %h lat %0d",
                     o, vals[i], vals[j], res, lat, exp, exp_lat);
          end
          step();
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00;
    rs1_i = '0; rs2_i = '0;
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
